// File: rtl/uart_rx_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_rx_pkg                                                          |
// | Shared constants, state encodings and helpers for the UART frame     |
// | loader: start-of-frame marker bytes, byte/frame FSM states, and the  |
// | oversample divider calculation.                                      |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
package uart_rx_pkg;

  localparam logic [7:0] SOF0 = 8'hAA;
  localparam logic [7:0] SOF1 = 8'h55;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} byte_state_t;

  typedef enum logic [1:0] {WAIT_SOF0, WAIT_SOF1, PAYLOAD, CHKSUM} frame_state_t;

  // Clocks per 16x oversample tick (integer division).
  function automatic int baud_div(input int clk_hz, input int baud);
    return clk_hz / (baud * 16);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_byte.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_rx_byte                                                         |
// | 8N1 UART byte receiver: 2-FF synchronizer (preset high), 16x         |
// | oversample tick generator and start/data/stop byte FSM.              |
// | Ports:                                                               |
// |   clk        in   system clock                                       |
// |   reset      in   asynchronous active-low reset                      |
// |   rx         in   serial input, idle high, asynchronous              |
// |   data       out  received byte (valid with byte_valid)              |
// |   byte_valid out  1-clk pulse: byte received with good stop bit      |
// |   ferr       out  1-clk pulse: stop bit sampled low, byte dropped    |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module uart_rx_byte
  import uart_rx_pkg::*;
#(
  parameter int DIV = 54
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data,
  output logic       byte_valid,
  output logic       ferr
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [1:0]    sync;
  logic          rx_s;
  logic [DW-1:0] div_cnt;
  logic          tick;

  byte_state_t state, state_d;
  logic [3:0]  tcnt, tcnt_d;
  logic [2:0]  bcnt, bcnt_d;
  logic [7:0]  shreg, shreg_d;
  logic        wait_hi, wait_hi_d;
  logic        bv_d, fe_d;

  assign rx_s = sync[1];
  assign data = shreg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sync <= 2'b11;
    else        sync <= {sync[0], rx};
  end

  // Divider is held in IDLE so tick phase is aligned to the start edge.
  assign tick = (div_cnt == DW'(DIV - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                      div_cnt <= '0;
    else if (state == IDLE || tick)  div_cnt <= '0;
    else                             div_cnt <= div_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      tcnt       <= 4'd0;
      bcnt       <= 3'd0;
      shreg      <= 8'd0;
      wait_hi    <= 1'b0;
      byte_valid <= 1'b0;
      ferr       <= 1'b0;
    end else begin
      state      <= state_d;
      tcnt       <= tcnt_d;
      bcnt       <= bcnt_d;
      shreg      <= shreg_d;
      wait_hi    <= wait_hi_d;
      byte_valid <= bv_d;
      ferr       <= fe_d;
    end
  end

  always_comb begin
    state_d   = state;
    tcnt_d    = tcnt;
    bcnt_d    = bcnt;
    shreg_d   = shreg;
    wait_hi_d = wait_hi;
    bv_d      = 1'b0;
    fe_d      = 1'b0;
    case (state)
      IDLE: begin
        tcnt_d    = 4'd0;
        bcnt_d    = 3'd0;
        wait_hi_d = 1'b0;
        if (!rx_s) state_d = START;
      end
      START: begin
        if (tick) begin
          if (tcnt == 4'd7) begin
            tcnt_d  = 4'd0;
            // Line back high at mid start bit: treat as a glitch.
            state_d = rx_s ? IDLE : DATA;
          end else begin
            tcnt_d = tcnt + 4'd1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (tcnt == 4'd15) begin
            tcnt_d  = 4'd0;
            shreg_d = {rx_s, shreg[7:1]};
            bcnt_d  = bcnt + 3'd1;
            if (bcnt == 3'd7) state_d = STOP;
          end else begin
            tcnt_d = tcnt + 4'd1;
          end
        end
      end
      STOP: begin
        if (wait_hi) begin
          // After a framing error, hold off until the line returns idle
          // so the low stop bit is not mistaken for a new start bit.
          if (rx_s) state_d = IDLE;
        end else if (tick) begin
          if (tcnt == 4'd15) begin
            tcnt_d = 4'd0;
            if (rx_s) begin
              bv_d    = 1'b1;
              state_d = IDLE;
            end else begin
              fe_d      = 1'b1;
              wait_hi_d = 1'b1;
            end
          end else begin
            tcnt_d = tcnt + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/uart_rx_frame_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_rx_frame_loader                                                 |
// | Receives an AA 55 framed image byte stream over UART and writes the  |
// | IMG_W*IMG_H payload bytes to a frame-buffer RAM port in raster order.|
// | Optional feature macro: RX_CHECKSUM_EN (trailing XOR checksum byte). |
// | Ports:                                                               |
// |   clk        in   system clock                                       |
// |   reset      in   asynchronous active-low reset                      |
// |   rx         in   UART serial input, idle high                       |
// |   wr_en      out  1-clk RAM write strobe                             |
// |   wr_addr    out  RAM address 0..IMG_W*IMG_H-1                       |
// |   wr_data    out  pixel byte                                         |
// |   busy       out  frame in progress                                  |
// |   frame_done out  1-clk pulse: frame complete                        |
// |   frame_err  out  sticky framing/checksum error, cleared on SOF      |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module uart_rx_frame_loader
  import uart_rx_pkg::*;
#(
  parameter int CLK_HZ = 100_000_000,
  parameter int BAUD   = 115200,
  parameter int IMG_W  = 172,
  parameter int IMG_H  = 240,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy,
  output logic              frame_done,
  output logic              frame_err
);

  localparam int                DIV  = baud_div(CLK_HZ, BAUD);
  localparam int                NPIX = IMG_W * IMG_H;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NPIX - 1);

  logic [7:0] rx_byte;
  logic       byte_valid;
  logic       ferr;

  uart_rx_byte #(.DIV(DIV)) u_rx (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .data       (rx_byte),
    .byte_valid (byte_valid),
    .ferr       (ferr)
  );

  frame_state_t      state, state_d;
  logic [ADDR_W-1:0] count;
  logic              done_pend;
  logic              start_frame, take, drop, finish_ok, finish_bad;

`ifdef RX_CHECKSUM_EN
  logic [7:0] csum;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)           csum <= 8'd0;
    else if (start_frame) csum <= 8'd0;
    else if (take)        csum <= csum ^ rx_byte;
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= WAIT_SOF0;
    else        state <= state_d;
  end

  always_comb begin
    state_d     = state;
    start_frame = 1'b0;
    take        = 1'b0;
    drop        = 1'b0;
    finish_ok   = 1'b0;
    finish_bad  = 1'b0;
    case (state)
      WAIT_SOF0: begin
        if (byte_valid && rx_byte == SOF0) state_d = WAIT_SOF1;
      end
      WAIT_SOF1: begin
        if (byte_valid) begin
          if (rx_byte == SOF1) begin
            state_d     = PAYLOAD;
            start_frame = 1'b1;
          end else if (rx_byte != SOF0) begin
            state_d = WAIT_SOF0;
          end
        end
      end
      PAYLOAD: begin
        if (byte_valid || ferr) begin
          take = byte_valid;
          drop = ferr;
          if (count == LAST) begin
`ifdef RX_CHECKSUM_EN
            state_d = CHKSUM;
`else
            state_d   = WAIT_SOF0;
            finish_ok = 1'b1;
`endif
          end
        end
      end
`ifdef RX_CHECKSUM_EN
      CHKSUM: begin
        if (byte_valid) begin
          state_d = WAIT_SOF0;
          if (rx_byte == csum) finish_ok  = 1'b1;
          else                 finish_bad = 1'b1;
        end else if (ferr) begin
          state_d    = WAIT_SOF0;
          finish_bad = 1'b1;
        end
      end
`endif
      default: state_d = WAIT_SOF0;
    endcase
  end

  // done_pend delays frame_done so it lands one clock after the last wr_en.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= 8'd0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      count      <= '0;
      done_pend  <= 1'b0;
    end else begin
      wr_en      <= take;
      done_pend  <= finish_ok;
      frame_done <= done_pend;
      if (start_frame) begin
        busy      <= 1'b1;
        wr_addr   <= '0;
        frame_err <= 1'b0;
        count     <= '0;
      end
      if (take) begin
        wr_data <= rx_byte;
        wr_addr <= count;
      end
      // Dropped bytes still consume an address to keep raster alignment.
      if (take || drop) count <= count + 1'b1;
      if (drop) frame_err <= 1'b1;
      if (finish_bad) begin
        frame_err <= 1'b1;
        busy      <= 1'b0;
      end
      if (done_pend) busy <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_frame_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_uart_rx_frame_loader                                              |
// | Self-checking bench: drives framed UART traffic with random payloads |
// | and gaps, compares RAM writes and status against a stream model.     |
// | CLK_HZ is scaled so one oversample tick is 4 clocks (16x ratio kept).|
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_uart_rx_frame_loader;

  localparam int BAUD   = 115200;
  localparam int DIV_T  = 4;
  localparam int CLK_HZ = BAUD * 16 * DIV_T;
  localparam int N      = 8;
  localparam int BIT    = 16 * DIV_T;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx = 1'b1;
  logic        wr_en;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;
  logic        busy;
  logic        frame_done;
  logic        frame_err;

  uart_rx_frame_loader #(
    .CLK_HZ(CLK_HZ), .BAUD(BAUD), .IMG_W(4), .IMG_H(2), .ADDR_W(16)
  ) dut (
    .clk(clk), .reset(reset), .rx(rx),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .frame_done(frame_done), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] d; bit ok; } sb_t;
  typedef struct { int a; int d; } wr_t;

  sb_t        stream[$];
  wr_t        obs[$];
  wr_t        exp_w[$];
  int         exp_done, exp_err;
  int         done_seen, bv_cnt;
  int         cyc = 0, last_wr_cyc = 0;
  int         n_chk = 0, n_err = 0;
  logic [7:0] pay [N];
  logic [7:0] pay_xor;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    wr_t w;
    if (wr_en) begin
      w.a = int'(wr_addr);
      w.d = int'(wr_data);
      obs.push_back(w);
      last_wr_cyc = cyc;
    end
    if (dut.u_rx.byte_valid) bv_cnt++;
    if (frame_done) begin
      done_seen++;
`ifndef RX_CHECKSUM_EN
      check("done_latency", cyc - last_wr_cyc, 1);
`endif
    end
  end

  task automatic clear_log();
    stream.delete();
    obs.delete();
    done_seen = 0;
    bv_cnt    = 0;
  endtask

  task automatic rand_payload();
    for (int i = 0; i < N; i++) pay[i] = 8'($urandom);
  endtask

  task automatic send_byte(input logic [7:0] d, input bit stop_ok);
    sb_t s;
    s.d = d;
    s.ok = stop_ok;
    stream.push_back(s);
    rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (BIT) @(negedge clk);
    end
    rx = stop_ok;
    repeat (BIT) @(negedge clk);
    if (!stop_ok) begin
      rx = 1'b1;
      repeat (BIT) @(negedge clk);
    end
    rx = 1'b1;
    repeat ($urandom_range(0, BIT / 4)) @(negedge clk);
  endtask

  task automatic send_sof();
    send_byte(8'hAA, 1'b1);
    send_byte(8'h55, 1'b1);
  endtask

  task automatic send_payload(input int bad);
    pay_xor = 8'd0;
    for (int i = 0; i < N; i++) begin
      send_byte(pay[i], i != bad);
      if (i != bad) pay_xor ^= pay[i];
    end
  endtask

  task automatic finish_frame();
`ifdef RX_CHECKSUM_EN
    send_byte(pay_xor, 1'b1);
`endif
    repeat (2 * BIT) @(negedge clk);
  endtask

  // Expected result computed from the byte stream: first adjacent AA,55
  // pair marks the start; the next N bytes are pixels 0..N-1.
  task automatic run_model();
    int         sof;
    logic [7:0] x;
    wr_t        w;
    sof = -1;
    x = 8'd0;
    exp_w.delete();
    exp_done = 0;
    exp_err  = 0;
    for (int k = 0; k + 1 < stream.size(); k++) begin
      if (stream[k].ok && stream[k+1].ok &&
          stream[k].d == 8'hAA && stream[k+1].d == 8'h55) begin
        sof = k + 2;
        break;
      end
    end
    if (sof < 0 || sof + N > stream.size()) return;
    for (int j = 0; j < N; j++) begin
      if (stream[sof+j].ok) begin
        w.a = j;
        w.d = int'(stream[sof+j].d);
        exp_w.push_back(w);
        x ^= stream[sof+j].d;
      end else begin
        exp_err = 1;
      end
    end
`ifdef RX_CHECKSUM_EN
    if (sof + N < stream.size() && stream[sof+N].ok && stream[sof+N].d == x)
      exp_done = 1;
    else
      exp_err = 1;
`else
    exp_done = 1;
`endif
  endtask

  task automatic compare_frame(input string tag);
    run_model();
    check({tag, "_nwr"}, obs.size(), exp_w.size());
    for (int i = 0; i < obs.size() && i < exp_w.size(); i++) begin
      check({tag, "_addr"}, obs[i].a, exp_w[i].a);
      check({tag, "_data"}, obs[i].d, exp_w[i].d);
    end
    check({tag, "_done"}, done_seen, exp_done);
    check({tag, "_err"}, frame_err, exp_err);
    check({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_frame_err", frame_err, 0);
    reset = 1'b1;
    repeat (2 * BIT) @(negedge clk);

    // 1: basic frame 00 11 .. 77
    clear_log();
    for (int i = 0; i < N; i++) pay[i] = 8'(i * 17);
    send_sof();
    check("t1_busy_after_sof", busy, 1);
    send_payload(-1);
    finish_frame();
    compare_frame("t1");

    // 2: stray bytes before the real SOF
    clear_log();
    rand_payload();
    send_byte(8'h12, 1'b1);
    send_byte(8'hAA, 1'b1);
    send_byte(8'h34, 1'b1);
    send_byte(8'hAA, 1'b1);
    check("t2_idle_nowrite", obs.size(), 0);
    send_sof();
    send_payload(-1);
    finish_frame();
    compare_frame("t2");

    // 3: short low glitch while idle
    clear_log();
    rx = 1'b0;
    repeat (3 * DIV_T) @(negedge clk);
    rx = 1'b1;
    repeat (3 * BIT) @(negedge clk);
    check("t3_glitch_bv", bv_cnt, 0);
    check("t3_glitch_wr", obs.size(), 0);
    rand_payload();
    send_sof();
    send_payload(-1);
    finish_frame();
    compare_frame("t3");

    // 4: framing error on payload byte 3, then a clean frame
    clear_log();
    rand_payload();
    send_sof();
    send_payload(3);
    finish_frame();
    compare_frame("t4");
    clear_log();
    rand_payload();
    send_sof();
    check("t4_err_cleared", frame_err, 0);
    send_payload(-1);
    finish_frame();
    compare_frame("t4b");

    // 5: reset after 4 payload bytes
    clear_log();
    rand_payload();
    send_sof();
    for (int i = 0; i < 4; i++) send_byte(pay[i], 1'b1);
    repeat (BIT / 2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("t5_rst_wr_en", wr_en, 0);
    check("t5_rst_wr_addr", wr_addr, 0);
    check("t5_rst_wr_data", wr_data, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_err", frame_err, 0);
    reset = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    check("t5_no_done", done_seen, 0);
    clear_log();
    rand_payload();
    send_sof();
    send_payload(-1);
    finish_frame();
    compare_frame("t5");

`ifdef RX_CHECKSUM_EN
    // 6: checksum good (FF) and bad (FE)
    for (int i = 0; i < N; i++) pay[i] = 8'(1 << i);
    clear_log();
    send_sof();
    send_payload(-1);
    send_byte(8'hFF, 1'b1);
    repeat (2 * BIT) @(negedge clk);
    compare_frame("t6_ok");
    check("t6_ok_done", done_seen, 1);
    clear_log();
    send_sof();
    send_payload(-1);
    send_byte(8'hFE, 1'b1);
    repeat (2 * BIT) @(negedge clk);
    compare_frame("t6_bad");
    check("t6_bad_err", frame_err, 1);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
